controle_servo_posicao: RTL

CONTROLE_SERVO_POSICAO -- requirements
Module: controle_servo_posicao

---
 rtl/controle_servo_posicao.sv | 120 ++++++++++++
 1 files changed

// File: rtl/controle_servo_posicao.sv
// Servo PWM generator: one pulse per period, width set by a clamped position latched at each period wrap.
// Optional macro CONTROLE_SERVO_DIV_EN compiles in a divider so the position request fires every PERIODOS_POR_PASSO periods.
module controle_servo_posicao #(
  parameter int PERIODO            = 1000000,
  parameter int LARGURA_MIN        = 50000,
  parameter int PASSO              = 1000,
  parameter int POS_MAX            = 49,
  parameter int N                  = 6,
  parameter int NP                 = 20,
  parameter int PERIODOS_POR_PASSO = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         liga,
  input  logic [N-1:0] posicao,
  output logic         pwm,
  output logic         pede_posicao,
  output logic [N-1:0] pos_atual,
  output logic         db_estado
);

  if (PERIODO < 2 || PERIODOS_POR_PASSO < 1 || POS_MAX < 0) begin : g_param_invalido
    $error("controle_servo_posicao: invalid parameters");
  end

  typedef enum logic {PARADO = 1'b0, ATIVO = 1'b1} estado_t;

  localparam logic [NP-1:0] ULTIMO    = NP'(PERIODO - 1);
  localparam logic [N-1:0]  POS_MAX_N = N'(POS_MAX);

  estado_t       estado_q, estado_d;
  logic [NP-1:0] contador_q, contador_d;
  logic [NP-1:0] largura_q, largura_d;
  logic [N-1:0]  pos_q, pos_d;
  logic [N-1:0]  pos_clamp;
  logic [NP-1:0] largura_nova;
  logic          fim_periodo;
  logic          pede;

  assign pos_clamp    = (posicao > POS_MAX_N) ? POS_MAX_N : posicao;
  assign largura_nova = NP'(LARGURA_MIN) + NP'(pos_clamp) * NP'(PASSO);
  assign fim_periodo  = (estado_q == ATIVO) && (contador_q == ULTIMO);

`ifdef CONTROLE_SERVO_DIV_EN
  localparam int DW = (PERIODOS_POR_PASSO > 1) ? $clog2(PERIODOS_POR_PASSO) : 1;
  localparam logic [DW-1:0] DIV_ULT = DW'(PERIODOS_POR_PASSO - 1);

  logic [DW-1:0] div_q, div_d;

  // Counts wraps; only the last wrap of each group requests a new position.
  always_comb begin
    div_d = div_q;
    if (estado_q == PARADO)
      div_d = '0;
    else if (fim_periodo)
      div_d = (div_q == DIV_ULT) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign pede = fim_periodo && (div_q == DIV_ULT);
`else
  assign pede = fim_periodo;
`endif

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    largura_d  = largura_q;
    pos_d      = pos_q;
    case (estado_q)
      PARADO: begin
        contador_d = '0;
        if (liga) begin
          estado_d  = ATIVO;
          pos_d     = pos_clamp;
          largura_d = largura_nova;
        end
      end
      ATIVO: begin
        // posicao is sampled here, before the external counter reacts to pede_posicao.
        if (fim_periodo) begin
          contador_d = '0;
          if (liga) begin
            pos_d     = pos_clamp;
            largura_d = largura_nova;
          end else begin
            estado_d = PARADO;
          end
        end else begin
          contador_d = contador_q + 1'b1;
        end
      end
      default: estado_d = PARADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= PARADO;
      contador_q <= '0;
      largura_q  <= '0;
      pos_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      largura_q  <= largura_d;
      pos_q      <= pos_d;
    end
  end

  assign pwm          = (estado_q == ATIVO) && (contador_q < largura_q);
  assign pede_posicao = pede;
  assign pos_atual    = pos_q;
  assign db_estado    = (estado_q == ATIVO);

endmodule
